avmm_downscale_host: RTL and testbench

- Avalon-MM master engine driving the downscaler's JTAG-style register slave from on-chip logic, replacing the host-side JTAG master for automated runs and regression.
- Sequence: configure ratios, stream source pixels into image memory, pulse start, poll done, read result pixels back as a byte stream, capture the performance counter.
- Sits between a pixel source/sink (valid/ready streams) and the slave's avs_* port.

---
 rtl/avmm_downscale_host_if.sv | 18 +
 rtl/avmm_downscale_host.sv | 230 +++++++++++++++++++++++
 tb/tb_avmm_downscale_host.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_downscale_host_if.sv
// Avalon-MM register bus between the host engine (master) and the downscaler
// register slave; no waitrequest, fixed read latency.
interface avmm_downscale_host_if;
    logic        avm_read;
    logic        avm_write;
    logic [7:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_read, avm_write, avm_address, avm_writedata,
        input  avm_readdata
    );
    modport slave (
        input  avm_read, avm_write, avm_address, avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/avmm_downscale_host.sv
// Avalon-MM host engine: configures the downscaler, loads the source image,
// starts it, polls for completion, streams back the result and reads PERF.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | waiting for cmd_start
// CFG_X     | write XRATIO
// CFG_Y     | write YRATIO
// LD_ADDR   | write WADDR = pix
// LD_WAIT   | wait for a source pixel (in_ready high)
// LD_DATA   | write WDATA = pixel, advance pix
// START     | write CTRL = 1
// POLL      | read STATUS
// P_WAIT    | wait read latency, decide done / timeout / retry
// P_GAP     | idle between polls
// RB_ADDR   | write WADDR = pix
// RB_RD     | read RDATA
// RB_WAIT   | wait read latency, capture result byte
// RB_OUT    | present result byte until sink accepts it
// PERF      | read PERF
// PF_WAIT   | wait read latency, capture perf_cycles
// FIN       | one-cycle done pulse
module avmm_downscale_host #(
    parameter int IMG_W    = 512,
    parameter int IMG_H    = 512,
    parameter int AW       = 18,
    parameter int RD_LAT   = 1,
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [31:0]           cmd_xratio,
    input  logic [31:0]           cmd_yratio,
    input  logic [AW-1:0]         cmd_out_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           perf_cycles,
    avmm_downscale_host_if.master avm
);

    localparam logic [7:0] REG_CTRL   = 8'd0;
    localparam logic [7:0] REG_XRATIO = 8'd1;
    localparam logic [7:0] REG_YRATIO = 8'd2;
    localparam logic [7:0] REG_WADDR  = 8'd3;
    localparam logic [7:0] REG_WDATA  = 8'd4;
    localparam logic [7:0] REG_RDATA  = 8'd5;
    localparam logic [7:0] REG_STATUS = 8'd6;
    localparam logic [7:0] REG_PERF   = 8'd7;

    localparam int TMAX = (RD_LAT > POLL_GAP) ? RD_LAT : POLL_GAP;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam int PW   = $clog2(POLL_MAX + 1);

    localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_H - 1);
    localparam logic [TW-1:0] LAT_LD   = TW'(RD_LAT - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(POLL_GAP - 1);
    localparam logic [PW-1:0] POLL_LD  = PW'(POLL_MAX);

    typedef enum logic [4:0] {
        S_IDLE, S_CFG_X, S_CFG_Y, S_LD_ADDR, S_LD_WAIT, S_LD_DATA, S_START,
        S_POLL, S_P_WAIT, S_P_GAP, S_RB_ADDR, S_RB_RD, S_RB_WAIT, S_RB_OUT,
        S_PERF, S_PF_WAIT, S_FIN
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   pix;
    logic [AW-1:0]   cnt_q;
    logic [31:0]     xratio_q, yratio_q;
    logic [7:0]      pix_byte;
    logic [7:0]      out_q;
    logic [TW-1:0]   tmr;
    logic [PW-1:0]   polls_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        avm.avm_read      = 1'b0;
        avm.avm_write     = 1'b0;
        avm.avm_address   = 8'd0;
        avm.avm_writedata = 32'd0;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        done              = 1'b0;
        busy              = (state != S_IDLE);
        case (state)
            S_IDLE:    if (cmd_start) state_nx = S_CFG_X;
            S_CFG_X: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = REG_XRATIO;
                avm.avm_writedata = xratio_q;
                state_nx          = S_CFG_Y;
            end
            S_CFG_Y: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = REG_YRATIO;
                avm.avm_writedata = yratio_q;
                state_nx          = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = REG_WADDR;
                avm.avm_writedata = 32'(pix);
                state_nx          = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_LD_DATA;
            end
            S_LD_DATA: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = REG_WDATA;
                avm.avm_writedata = {24'd0, pix_byte};
                state_nx          = (pix == LAST_PIX) ? S_START : S_LD_ADDR;
            end
            S_START: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = REG_CTRL;
                avm.avm_writedata = 32'd1;
                state_nx          = S_POLL;
            end
            S_POLL: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = REG_STATUS;
                state_nx        = S_P_WAIT;
            end
            S_P_WAIT: begin
                // Done wins over timeout when the final permitted poll sees it set.
                if (tmr == '0) begin
                    if (avm.avm_readdata[0])   state_nx = S_RB_ADDR;
                    else if (polls_left == '0) state_nx = S_FIN;
                    else                       state_nx = S_P_GAP;
                end
            end
            S_P_GAP:   if (tmr == '0) state_nx = S_POLL;
            S_RB_ADDR: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = REG_WADDR;
                avm.avm_writedata = 32'(pix);
                state_nx          = S_RB_RD;
            end
            S_RB_RD: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = REG_RDATA;
                state_nx        = S_RB_WAIT;
            end
            S_RB_WAIT: if (tmr == '0) state_nx = S_RB_OUT;
            S_RB_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = (pix == cnt_q - AW'(1)) ? S_PERF : S_RB_ADDR;
            end
            S_PERF: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = REG_PERF;
                state_nx        = S_PF_WAIT;
            end
            S_PF_WAIT: if (tmr == '0) state_nx = S_FIN;
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    assign out_data = out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix         <= '0;
            cnt_q       <= '0;
            xratio_q    <= '0;
            yratio_q    <= '0;
            pix_byte    <= '0;
            out_q       <= '0;
            tmr         <= '0;
            polls_left  <= '0;
            error       <= 1'b0;
            perf_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_start) begin
                    xratio_q   <= cmd_xratio;
                    yratio_q   <= cmd_yratio;
                    cnt_q      <= cmd_out_count;
                    pix        <= '0;
                    polls_left <= POLL_LD;
                    error      <= 1'b0;
                end
                S_LD_WAIT: if (in_valid) pix_byte <= in_data;
                S_LD_DATA: if (pix != LAST_PIX) pix <= pix + AW'(1);
                S_POLL: begin
                    tmr        <= LAT_LD;
                    polls_left <= polls_left - PW'(1);
                end
                S_P_WAIT: begin
                    if (tmr != '0)                 tmr   <= tmr - TW'(1);
                    else if (avm.avm_readdata[0])  pix   <= '0;
                    else if (polls_left == '0)     error <= 1'b1;
                    else                           tmr   <= GAP_LD;
                end
                S_P_GAP:  if (tmr != '0) tmr <= tmr - TW'(1);
                S_RB_RD, S_PERF: tmr <= LAT_LD;
                S_RB_WAIT: begin
                    if (tmr != '0) tmr   <= tmr - TW'(1);
                    else           out_q <= avm.avm_readdata[7:0];
                end
                S_RB_OUT: if (out_ready && (pix != cnt_q - AW'(1))) pix <= pix + AW'(1);
                S_PF_WAIT: begin
                    if (tmr != '0) tmr         <= tmr - TW'(1);
                    else           perf_cycles <= avm.avm_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_downscale_host.sv
// Randomized bench for avmm_downscale_host: register-slave model, expected
// bus-transaction and output-beat queues, and a per-cycle compare process.
module tb_avmm_downscale_host;
    localparam int IMG_W = 2;
    localparam int IMG_H = 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = 4;
    localparam int RL    = 3;
    localparam int PG    = 4;
    localparam int PMAX  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic [31:0]   cmd_xratio = '0;
    logic [31:0]   cmd_yratio = '0;
    logic [AW-1:0] cmd_out_count = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b0;
    logic          busy, done, error;
    logic [31:0]   perf_cycles;

    avmm_downscale_host_if bus();

    avmm_downscale_host #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .RD_LAT(RL), .POLL_GAP(PG), .POLL_MAX(PMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_xratio(cmd_xratio), .cmd_yratio(cmd_yratio),
        .cmd_out_count(cmd_out_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error), .perf_cycles(perf_cycles),
        .avm(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // ---------------- register slave model ----------------
    logic [7:0]  mem [0:15];
    logic [31:0] s_waddr = '0;
    int          s_polls = 0;
    int          done_after = 0;
    logic [31:0] perf_val = '0;
    logic [31:0] rpipe [RL];
    logic [RL-1:0] rvalid = '0;
    logic [31:0] garbage = '0;

    function automatic logic [31:0] slave_rd(input logic [7:0] a);
        case (a)
            8'd5:    return {24'd0, mem[s_waddr[3:0]]};
            8'd6:    return {31'd0, (done_after != 0 && s_polls + 1 >= done_after)};
            8'd7:    return perf_val;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        garbage  <= $urandom;
        rvalid   <= {rvalid[RL-2:0], bus.avm_read};
        rpipe[0] <= slave_rd(bus.avm_address);
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
        if (bus.avm_read && bus.avm_address == 8'd6) s_polls <= s_polls + 1;
        if (bus.avm_write) begin
            case (bus.avm_address)
                8'd0:    if (bus.avm_writedata[0]) s_polls <= 0;
                8'd3:    s_waddr <= bus.avm_writedata;
                8'd4:    mem[s_waddr[3:0]] <= bus.avm_writedata[7:0];
                default: ;
            endcase
        end
    end

    // Off-cycle read data is random so early or late sampling shows up.
    assign bus.avm_readdata = rvalid[RL-1] ? rpipe[RL-1] : garbage;

    // ---------------- expectations and compare process ----------------
    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q [$];
    logic [7:0]  exp_out [$];
    bit          exp_err = 1'b0;
    logic [31:0] exp_perf = '0;

    int  n_access = 0, n_status = 0, n_done = 0;
    int  cyc = 0, since_rd = 100, last_poll = 0;
    bit  first_poll = 1'b1, prev_hold = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_od = '0;

    always @(negedge clk) begin
        acc_t e;
        logic [7:0] eo;
        cyc++;
        if (rst) begin
            chk({bus.avm_read, bus.avm_write, busy, in_ready, out_valid, done} == 6'b0,
                "reset_quiet",
                32'({bus.avm_read, bus.avm_write, busy, in_ready, out_valid, done}), 32'd0);
            since_rd  = 100;
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            since_rd++;
            if (bus.avm_read || bus.avm_write) begin
                n_access++;
                chk(!(bus.avm_read && bus.avm_write), "one_strobe", 32'd1, 32'd0);
                chk(since_rd > RL, "read_latency_gap", 32'(since_rd), 32'(RL + 1));
                chk(busy && !in_ready && !out_valid, "strobe_while_stalled",
                    32'({busy, in_ready, out_valid}), 32'b100);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_access", 32'(bus.avm_address), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.wr == bus.avm_write && e.addr == bus.avm_address, "access_kind",
                        32'({bus.avm_write, bus.avm_address}), 32'({e.wr, e.addr}));
                    if (e.wr) chk(bus.avm_writedata == e.data, "writedata", bus.avm_writedata, e.data);
                end
                if (bus.avm_read) begin
                    since_rd = 0;
                    if (bus.avm_address == 8'd6) begin
                        n_status++;
                        if (!first_poll)
                            chk(cyc - last_poll == RL + PG + 1, "poll_gap",
                                32'(cyc - last_poll), 32'(RL + PG + 1));
                        first_poll = 1'b0;
                        last_poll  = cyc;
                    end
                end
                if (bus.avm_write && bus.avm_address == 8'd0) first_poll = 1'b1;
            end
            if (prev_hold)
                chk(out_valid && out_data == prev_od, "out_hold", 32'({out_valid, out_data}),
                    32'({1'b1, prev_od}));
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    chk(1'b0, "extra_out_beat", 32'(out_data), 32'd0);
                end else begin
                    eo = exp_out.pop_front();
                    chk(out_data == eo, "out_data", 32'(out_data), 32'(eo));
                end
            end
            if (done) begin
                n_done++;
                chk(!prev_done, "done_one_cycle", 32'(prev_done), 32'd0);
                chk(error == exp_err, "error_at_done", 32'(error), 32'(exp_err));
                chk(perf_cycles == exp_perf, "perf_at_done", perf_cycles, exp_perf);
            end
            prev_hold = out_valid && !out_ready;
            prev_od   = out_data;
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    bit run_fin = 1'b0;
    bit stall_pending = 1'b0;

    function automatic void push_acc(input bit wr, input logic [7:0] a, input logic [31:0] d);
        acc_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic run(input logic [31:0] xr, input logic [31:0] yr, input int cnt,
                       input int dafter, input logic [31:0] pv, input int gap_at,
                       input bit ostall, output int nacc, output int nstat);
        logic [7:0] px [NPIX];
        bit rb;
        int npoll, a0, s0;
        for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom_range(0, 255));
        if (ostall) px[0] = 8'hA5;
        done_after = dafter;
        perf_val   = pv;
        rb    = (dafter >= 1 && dafter <= PMAX);
        npoll = rb ? dafter : PMAX;
        push_acc(1'b1, 8'd1, xr);
        push_acc(1'b1, 8'd2, yr);
        for (int k = 0; k < NPIX; k++) begin
            push_acc(1'b1, 8'd3, 32'(k));
            push_acc(1'b1, 8'd4, {24'd0, px[k]});
        end
        push_acc(1'b1, 8'd0, 32'd1);
        for (int p = 0; p < npoll; p++) push_acc(1'b0, 8'd6, 32'd0);
        if (rb) begin
            for (int j = 0; j < cnt; j++) begin
                push_acc(1'b1, 8'd3, 32'(j));
                push_acc(1'b0, 8'd5, 32'd0);
                exp_out.push_back(px[j]);
            end
            push_acc(1'b0, 8'd7, 32'd0);
            exp_perf = pv;
        end
        exp_err = !rb;
        a0 = n_access;
        s0 = n_status;
        stall_pending = ostall;
        run_fin = 1'b0;

        @(negedge clk);
        cmd_xratio = xr; cmd_yratio = yr; cmd_out_count = AW'(cnt); cmd_start = 1'b1;
        @(negedge clk);
        chk(busy == 1'b1, "accept_busy", 32'(busy), 32'd1);
        chk(error == 1'b0, "accept_clears_error", 32'(error), 32'd0);
        // A second request while busy, with different operands, must be ignored.
        cmd_xratio = ~xr; cmd_yratio = ~yr; cmd_out_count = AW'(cnt + 1);
        @(negedge clk);
        cmd_start = 1'b0;

        fork
            begin : pixel_src
                int n, g0;
                for (int k = 0; k < NPIX; k++) begin
                    @(negedge clk);
                    if (k == gap_at) begin
                        repeat (5) @(negedge clk);
                        g0 = n_access;
                        repeat (45) @(negedge clk);
                        chk(n_access == g0, "load_gap_quiet", 32'(n_access - g0), 32'd0);
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    in_valid = 1'b1;
                    in_data  = px[k];
                    n = 0;
                    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
                    chk(n < 1000, "in_ready_timeout", 32'(n), 32'd1000);
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                    in_data = 8'($urandom_range(0, 255));
                end
            end
            begin : sink
                int s_acc;
                while (!run_fin) begin
                    @(negedge clk);
                    if (stall_pending && out_valid) begin
                        chk(out_data == 8'hA5, "stall_first_byte", 32'(out_data), 32'hA5);
                        out_ready = 1'b0;
                        s_acc = n_access;
                        repeat (20) @(negedge clk);
                        chk(n_access == s_acc, "stall_quiet", 32'(n_access - s_acc), 32'd0);
                        chk(out_valid && out_data == 8'hA5, "stall_hold",
                            32'({out_valid, out_data}), 32'h1A5);
                        out_ready = 1'b1;
                        stall_pending = 1'b0;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            end
            begin : waiter
                int n;
                n = 0;
                while (!done && n < 4000) begin @(negedge clk); n++; end
                chk(done == 1'b1, "done_timeout", 32'(n), 32'd4000);
                run_fin = 1'b1;
            end
        join

        nacc  = n_access - a0;
        nstat = n_status - s0;
        chk(exp_q.size() == 0, "missing_accesses", 32'(exp_q.size()), 32'd0);
        chk(exp_out.size() == 0, "missing_out_beats", 32'(exp_out.size()), 32'd0);
        exp_q.delete();
        exp_out.delete();
        for (int k = 0; k < NPIX; k++)
            chk(mem[k] == px[k], "mem_contents", 32'(mem[k]), 32'(px[k]));
        @(negedge clk);
        chk(busy == 1'b0, "idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_load();
        logic [7:0] p0;
        int n;
        p0 = 8'($urandom_range(0, 255));
        done_after = 1;
        push_acc(1'b1, 8'd1, 32'h11);
        push_acc(1'b1, 8'd2, 32'h22);
        push_acc(1'b1, 8'd3, 32'd0);
        push_acc(1'b1, 8'd4, {24'd0, p0});
        @(negedge clk);
        cmd_xratio = 32'h11; cmd_yratio = 32'h22; cmd_out_count = AW'(1); cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        in_valid = 1'b1;
        in_data  = p0;
        n = 0;
        while (!(bus.avm_write && bus.avm_address == 8'd4) && n < 200) begin
            @(negedge clk); n++;
        end
        chk(n < 200, "reach_ld_data", 32'(n), 32'd200);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
        chk(!bus.avm_read && !bus.avm_write, "reset_strobes",
            32'({bus.avm_read, bus.avm_write}), 32'd0);
        chk(error == 1'b0, "reset_error", 32'(error), 32'd0);
        exp_q.delete();
        exp_out.delete();
        exp_perf = '0;
        exp_err  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int nacc, nstat;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        chk(perf_cycles == 32'd0, "reset_perf", perf_cycles, 32'd0);
        chk(error == 1'b0, "reset_error_init", 32'(error), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Slave never reports done: POLL_MAX reads, error, done, no readback.
        run(32'h0001_0000, 32'h0002_0000, 1, 0, 32'h5555_5555, -1, 1'b0, nacc, nstat);
        chk(nstat == 4, "timeout_status_reads", 32'(nstat), 32'd4);
        chk(error == 1'b1, "timeout_error", 32'(error), 32'd1);
        chk(perf_cycles == 32'd0, "timeout_perf_unchanged", perf_cycles, 32'd0);
        chk(nacc == 2 + 8 + 1 + 4, "timeout_access_count", 32'(nacc), 32'd15);

        // Done on the third poll, one result pixel.
        run(32'h0001_8000, 32'h0002_4000, 1, 3, 32'h0000_1234, -1, 1'b0, nacc, nstat);
        chk(nacc == 17, "trace_access_count", 32'(nacc), 32'd17);
        chk(nstat == 3, "trace_status_reads", 32'(nstat), 32'd3);
        chk(perf_cycles == 32'h0000_1234, "perf_value", perf_cycles, 32'h1234);
        chk(error == 1'b0, "trace_error_clear", 32'(error), 32'd0);

        // Source stalls 50 cycles before pixel 2; full readback.
        run(32'hA, 32'hB, 4, 1, 32'hCAFE_0001, 2, 1'b0, nacc, nstat);
        chk(nacc == 2 + 8 + 1 + 1 + 8 + 1, "gap_access_count", 32'(nacc), 32'd21);

        // Sink holds off 20 cycles on a 0xA5 first byte.
        run(32'hC, 32'hD, 2, 2, 32'h0BAD_F00D, -1, 1'b1, nacc, nstat);

        for (int r = 0; r < 4; r++)
            run($urandom, $urandom, $urandom_range(1, NPIX), $urandom_range(0, PMAX + 1),
                $urandom, $urandom_range(0, 1) != 0 ? int'($urandom_range(0, NPIX - 1)) : -1,
                1'b0, nacc, nstat);

        // Leave error set, then reset in the middle of the load.
        run(32'h1, 32'h2, 1, 0, 32'h0, -1, 1'b0, nacc, nstat);
        reset_mid_load();
        @(negedge clk);
        chk(perf_cycles == 32'd0, "post_reset_perf", perf_cycles, 32'd0);
        run(32'h3, 32'h4, 3, 4, 32'h7777_0003, -1, 1'b0, nacc, nstat);
        chk(perf_cycles == 32'h7777_0003, "post_reset_run_perf", perf_cycles, 32'h7777_0003);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
